mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the instruction-fetch requester and the load/store requester.
- Sequences each transaction through grant, memory wait and response.
- Drives the select of the 32-bit 2:1 address/data mux in front of memory (0 = fetch, 1 = data).
- Bounds every access with a timeout counter so a hung memory cannot stall the core forever.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 64, max cycles in BUSY without mem_ack before an error response. 0 = no timeout.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  AW  fetch address
- if_gnt  out  1  one-cycle grant pulse to fetch
- if_rvalid  out  1  one-cycle response pulse to fetch
- d_req  in  1  load/store request; held until d_gnt
- d_we  in  1  1 = store
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_gnt  out  1  one-cycle grant pulse to data
- d_rvalid  out  1  one-cycle response pulse to data
- rdata  out  DW  response data, shared by both requesters; valid with either rvalid
- err  out  1  timeout flag, qualified by rvalid
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  latched write enable (0 for fetch)
- mem_addr  out  AW  latched address
- mem_wdata  out  DW  latched store data (0 for fetch)
- mem_rdata  in  DW  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion
- sel  out  1  owner / mux select; 0 = fetch, 1 = data

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0 (gnt, rvalid, mem_req, mem_we, mem_addr, mem_wdata, rdata, err, sel, counter). Reset mid-transaction drops the transaction; no rvalid is produced.
- FSM states: IDLE, BUSY, RESP. All outputs are registered.
- IDLE:
  - If any req is high, pick a winner and go to BUSY.
  - On that edge: latch addr/we/wdata into mem_*, set sel to the owner, assert mem_req, pulse the owner's gnt for exactly the first BUSY cycle, clear the counter.
  - No req: stay in IDLE.
- Arbitration:
  - Fixed priority: d_req wins over if_req.
  - The loser keeps its req high and is considered again at the next IDLE.
- BUSY:
  - mem_req and mem_* stay stable.
  - On mem_ack: capture mem_rdata into rdata, set err = 0, go to RESP, drop mem_req.
  - The counter increments each BUSY cycle without mem_ack. When it reaches TIMEOUT (TIMEOUT != 0): set rdata = 0, err = 1, go to RESP, drop mem_req.
  - mem_ack wins over timeout if both occur in the same cycle.
- RESP:
  - Owner's rvalid = 1 for exactly one cycle, with rdata and err.
  - sel is held.
  - Next state is IDLE.
- Latency: req at cycle 0 → gnt + mem_req at cycle 1 → mem_ack at cycle 1 → rvalid at cycle 2. Minimum 3 cycles per transaction.
- Ignored inputs:
  - mem_ack in IDLE or RESP is ignored.
  - New reqs during BUSY or RESP are not granted.
  - A req dropped before grant is simply not served.
- Timer: counter width is clog2(TIMEOUT+1) bits and never wraps; it saturates at TIMEOUT.
- Invariants:
  - if_gnt and d_gnt are never high together.
  - if_rvalid and d_rvalid are never high together.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: adds a last-owner flop (reset 0 = fetch). On simultaneous requests, the requester that was not last served wins. A single request is served directly.
- Undefined: fixed data-over-fetch priority; no extra flop.

Test Plan:
- Single fetch: if_req = 1, if_addr = 0x0000_0010, mem_ack in first BUSY cycle with mem_rdata = 0x0050_0093 → if_gnt at cycle 1, mem_addr = 0x10, mem_we = 0, sel = 0, if_rvalid with rdata = 0x0050_0093 at cycle 2.
- Store: d_req = 1, d_we = 1, d_addr = 0x100, d_wdata = 0xDEAD_BEEF, mem_ack after 3 wait cycles → mem_we = 1 and mem_wdata = 0xDEAD_BEEF held for 4 cycles, sel = 1, d_rvalid once, err = 0.
- Contention: if_req and d_req both high at cycle 0 → d_gnt first. Fetch is granted after the data RESP. With ARB_ROUND_ROBIN_EN and a repeat contention, the next winner is fetch.
- Timeout: TIMEOUT = 4, no mem_ack → mem_req high for 4 cycles, then owner rvalid with err = 1 and rdata = 0. A late mem_ack in IDLE is ignored.
- Reset mid-BUSY: assert rst during a wait → all outputs 0 immediately (asynchronously), no rvalid. A new request after rst deasserts completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one unified memory port between the instruction-fetch requester
// and the load/store requester. Each transaction runs IDLE -> BUSY -> RESP:
// the winner is granted and its request is latched onto the memory port,
// the arbiter waits for mem_ack (bounded by a timeout counter), and the
// owner then gets a one-cycle response pulse. Every output is registered.
//
// Optional build macro: ARB_ROUND_ROBIN_EN
//   undefined : data requester always beats fetch on contention
//   defined   : a last-owner flop alternates the winner on contention
//
// Parameters:
//   AW      address width
//   DW      data width
//   TIMEOUT BUSY cycles without mem_ack before an error response (0 = never)
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   if_req, if_addr               fetch request, held until if_gnt
//   if_gnt, if_rvalid             fetch grant / response pulses
//   d_req, d_we, d_addr, d_wdata  load/store request, held until d_gnt
//   d_gnt, d_rvalid               data grant / response pulses
//   rdata, err                    shared response data and timeout flag
//   mem_req, mem_we, mem_addr,
//   mem_wdata                     latched memory request
//   mem_rdata, mem_ack            memory read data and completion
//   sel                           owner / address-data mux select (1 = data)

module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          sel
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // A zero TIMEOUT still needs a legal one-bit counter.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          grant_data;
  logic          timeout_hit;
  logic          cnt_can_inc;

  logic          if_gnt_nxt, d_gnt_nxt;
  logic          if_rvalid_nxt, d_rvalid_nxt;
  logic [DW-1:0] rdata_nxt;
  logic          err_nxt;
  logic          mem_req_nxt, mem_we_nxt;
  logic [AW-1:0] mem_addr_nxt;
  logic [DW-1:0] mem_wdata_nxt;
  logic          sel_nxt;

  // The timeout fires on the edge that ends the TIMEOUT-th waiting cycle,
  // i.e. when the counter already holds TIMEOUT-1 and still no ack.
  generate
    if (TIMEOUT > 0) begin : g_timeout
      localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
      assign timeout_hit = (cnt == CNT_LAST);
      assign cnt_can_inc = (cnt != CNT_MAX);
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
      assign cnt_can_inc = 1'b0;
    end
  endgenerate

`ifdef ARB_ROUND_ROBIN_EN
  // Remembers who was granted last (0 = fetch) so contention alternates.
  logic last_owner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner <= 1'b0;
    end else if (state == IDLE && (if_req || d_req)) begin
      last_owner <= grant_data;
    end
  end

  // On contention the requester not served last wins; a lone request wins outright.
  always_comb begin
    if (if_req && d_req) begin
      grant_data = ~last_owner;
    end else begin
      grant_data = d_req;
    end
  end
`else
  // Fixed priority: data always wins over fetch.
  always_comb begin
    grant_data = d_req;
  end
`endif

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      rdata     <= '0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      sel       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      if_gnt    <= if_gnt_nxt;
      d_gnt     <= d_gnt_nxt;
      if_rvalid <= if_rvalid_nxt;
      d_rvalid  <= d_rvalid_nxt;
      rdata     <= rdata_nxt;
      err       <= err_nxt;
      mem_req   <= mem_req_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      sel       <= sel_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (if_req || d_req) state_nxt = BUSY;
      BUSY: if (mem_ack || timeout_hit) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs. Grant and response pulses
  // default low so they last exactly one cycle; everything else holds.
  always_comb begin
    if_gnt_nxt    = 1'b0;
    d_gnt_nxt     = 1'b0;
    if_rvalid_nxt = 1'b0;
    d_rvalid_nxt  = 1'b0;
    rdata_nxt     = rdata;
    err_nxt       = err;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    sel_nxt       = sel;
    cnt_nxt       = cnt;
    case (state)
      IDLE: begin
        if (if_req || d_req) begin
          mem_req_nxt = 1'b1;
          cnt_nxt     = '0;
          sel_nxt     = grant_data;
          if (grant_data) begin
            d_gnt_nxt     = 1'b1;
            mem_we_nxt    = d_we;
            mem_addr_nxt  = d_addr;
            mem_wdata_nxt = d_wdata;
          end else begin
            if_gnt_nxt    = 1'b1;
            mem_we_nxt    = 1'b0;
            mem_addr_nxt  = if_addr;
            mem_wdata_nxt = '0;
          end
        end
      end
      BUSY: begin
        // A real ack beats a timeout landing on the same edge.
        if (mem_ack) begin
          rdata_nxt     = mem_rdata;
          err_nxt       = 1'b0;
          mem_req_nxt   = 1'b0;
          if_rvalid_nxt = ~sel;
          d_rvalid_nxt  = sel;
        end else if (timeout_hit) begin
          rdata_nxt     = '0;
          err_nxt       = 1'b1;
          mem_req_nxt   = 1'b0;
          if_rvalid_nxt = ~sel;
          d_rvalid_nxt  = sel;
          cnt_nxt       = CNT_MAX;
        end else if (cnt_can_inc) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//
// Directed self-checking bench for mem_port_arbiter built with TIMEOUT = 4.
// Inputs change 1 ns after each rising edge and outputs are sampled there,
// so every check reflects the registered state after that edge.

module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] rdata;
  logic          err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          sel;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .rdata(rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .sel(sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drives every requester and memory input in one go.
  task automatic applyStimulus(input logic ir, input logic [AW-1:0] ia,
                               input logic dr, input logic dwe, input logic [AW-1:0] da,
                               input logic [DW-1:0] dwd, input logic ack, input logic [DW-1:0] rd);
    if_req    = ir;
    if_addr   = ia;
    d_req     = dr;
    d_we      = dwe;
    d_addr    = da;
    d_wdata   = dwd;
    mem_ack   = ack;
    mem_rdata = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // The two grants and the two responses must never overlap.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("gnt_exclusive", 64'(if_gnt & d_gnt), 64'd0);
      checkOutput("rvalid_exclusive", 64'(if_rvalid & d_rvalid), 64'd0);
    end
  end

  initial begin
    rst = 1'b1;
    applyStimulus(0, '0, 0, 0, '0, '0, 0, '0);
    #1;
    checkOutput("rst_mem_req", 64'(mem_req), 64'd0);
    checkOutput("rst_sel", 64'(sel), 64'd0);
    checkOutput("rst_rdata", 64'(rdata), 64'd0);
    checkOutput("rst_gnt", 64'({if_gnt, d_gnt}), 64'd0);
    step();
    step();
    rst = 1'b0;

    // Single fetch, ack in the first BUSY cycle.
    applyStimulus(1, 32'h0000_0010, 0, 0, '0, '0, 0, '0);
    step();
    checkOutput("f_if_gnt", 64'(if_gnt), 64'd1);
    checkOutput("f_d_gnt", 64'(d_gnt), 64'd0);
    checkOutput("f_mem_req", 64'(mem_req), 64'd1);
    checkOutput("f_mem_addr", 64'(mem_addr), 64'h10);
    checkOutput("f_mem_we", 64'(mem_we), 64'd0);
    checkOutput("f_sel", 64'(sel), 64'd0);
    applyStimulus(0, '0, 0, 0, '0, '0, 1, 32'h0050_0093);
    step();
    checkOutput("f_if_rvalid", 64'(if_rvalid), 64'd1);
    checkOutput("f_rdata", 64'(rdata), 64'h0050_0093);
    checkOutput("f_err", 64'(err), 64'd0);
    checkOutput("f_mem_req_drop", 64'(mem_req), 64'd0);
    checkOutput("f_gnt_pulse", 64'(if_gnt), 64'd0);
    applyStimulus(0, '0, 0, 0, '0, '0, 0, '0);
    step();
    checkOutput("f_rvalid_pulse", 64'(if_rvalid), 64'd0);

    // Store with three wait cycles; the ack lands on the timeout edge and wins.
    applyStimulus(0, '0, 1, 1, 32'h100, 32'hDEAD_BEEF, 0, '0);
    step();
    checkOutput("s_d_gnt", 64'(d_gnt), 64'd1);
    checkOutput("s_sel", 64'(sel), 64'd1);
    applyStimulus(0, '0, 0, 0, '0, '0, 0, '0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("s_mem_req", 64'(mem_req), 64'd1);
      checkOutput("s_mem_we", 64'(mem_we), 64'd1);
      checkOutput("s_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
      checkOutput("s_mem_addr", 64'(mem_addr), 64'h100);
      step();
    end
    checkOutput("s_mem_req_last", 64'(mem_req), 64'd1);
    checkOutput("s_d_gnt_once", 64'(d_gnt), 64'd0);
    applyStimulus(0, '0, 0, 0, '0, '0, 1, 32'h1234_5678);
    step();
    checkOutput("s_d_rvalid", 64'(d_rvalid), 64'd1);
    checkOutput("s_if_rvalid", 64'(if_rvalid), 64'd0);
    checkOutput("s_err", 64'(err), 64'd0);
    checkOutput("s_rdata", 64'(rdata), 64'h1234_5678);
    applyStimulus(0, '0, 0, 0, '0, '0, 0, '0);
    step();
    checkOutput("s_rvalid_pulse", 64'(d_rvalid), 64'd0);

    // Contention: data first, the held fetch is served at the next IDLE.
    applyStimulus(1, 32'h0000_0200, 1, 0, 32'h300, '0, 0, '0);
    step();
    checkOutput("c1_d_gnt", 64'(d_gnt), 64'd1);
    checkOutput("c1_if_gnt", 64'(if_gnt), 64'd0);
    checkOutput("c1_sel", 64'(sel), 64'd1);
    applyStimulus(1, 32'h0000_0200, 0, 0, '0, '0, 1, 32'hA);
    step();
    checkOutput("c1_d_rvalid", 64'(d_rvalid), 64'd1);
    checkOutput("c1_no_gnt_resp", 64'(if_gnt), 64'd0);
    applyStimulus(1, 32'h0000_0200, 0, 0, '0, '0, 0, '0);
    step();
    step();
    checkOutput("c1_if_gnt_late", 64'(if_gnt), 64'd1);
    checkOutput("c1_sel_fetch", 64'(sel), 64'd0);
    checkOutput("c1_mem_addr", 64'(mem_addr), 64'h200);
    applyStimulus(0, '0, 0, 0, '0, '0, 1, 32'hB);
    step();
    checkOutput("c1_if_rvalid", 64'(if_rvalid), 64'd1);
    applyStimulus(0, '0, 0, 0, '0, '0, 0, '0);
    step();

    // Repeat contention: fetch was served last so data wins; with both still
    // requesting, the next winner depends on the arbitration mode.
    applyStimulus(1, 32'h0000_0400, 1, 1, 32'h500, 32'h55, 0, '0);
    step();
    checkOutput("c2_d_gnt", 64'(d_gnt), 64'd1);
    applyStimulus(1, 32'h0000_0400, 1, 1, 32'h500, 32'h55, 1, 32'hC);
    step();
    checkOutput("c2_d_rvalid", 64'(d_rvalid), 64'd1);
    checkOutput("c2_no_gnt_resp", 64'({if_gnt, d_gnt}), 64'd0);
    applyStimulus(1, 32'h0000_0400, 1, 1, 32'h500, 32'h55, 0, '0);
    step();
    step();
`ifdef ARB_ROUND_ROBIN_EN
    checkOutput("c2_next_if_gnt", 64'(if_gnt), 64'd1);
    checkOutput("c2_next_sel", 64'(sel), 64'd0);
`else
    checkOutput("c2_next_d_gnt", 64'(d_gnt), 64'd1);
    checkOutput("c2_next_sel", 64'(sel), 64'd1);
`endif
    applyStimulus(0, '0, 0, 0, '0, '0, 1, 32'hD);
    step();
    applyStimulus(0, '0, 0, 0, '0, '0, 0, '0);
    step();

    // Timeout: no ack for four BUSY cycles gives an error response.
    applyStimulus(1, 32'h0000_0020, 0, 0, '0, '0, 0, '0);
    step();
    checkOutput("t_if_gnt", 64'(if_gnt), 64'd1);
    applyStimulus(0, '0, 0, 0, '0, '0, 0, '0);
    for (int i = 0; i < TO; i++) begin
      checkOutput("t_mem_req", 64'(mem_req), 64'd1);
      checkOutput("t_no_rvalid", 64'(if_rvalid), 64'd0);
      step();
    end
    checkOutput("t_if_rvalid", 64'(if_rvalid), 64'd1);
    checkOutput("t_err", 64'(err), 64'd1);
    checkOutput("t_rdata", 64'(rdata), 64'd0);
    checkOutput("t_mem_req_drop", 64'(mem_req), 64'd0);
    applyStimulus(0, '0, 0, 0, '0, '0, 1, 32'hEE);
    step();
    step();
    checkOutput("t_late_ack_req", 64'(mem_req), 64'd0);
    checkOutput("t_late_ack_rvalid", 64'({if_rvalid, d_rvalid}), 64'd0);
    checkOutput("t_late_ack_gnt", 64'({if_gnt, d_gnt}), 64'd0);
    applyStimulus(0, '0, 0, 0, '0, '0, 0, '0);
    step();

    // Reset in the middle of a wait drops the transaction at once.
    applyStimulus(0, '0, 1, 1, 32'h600, 32'h66, 0, '0);
    step();
    checkOutput("r_d_gnt", 64'(d_gnt), 64'd1);
    applyStimulus(0, '0, 0, 0, '0, '0, 0, '0);
    step();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("r_mem_req", 64'(mem_req), 64'd0);
    checkOutput("r_sel", 64'(sel), 64'd0);
    checkOutput("r_mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("r_mem_we", 64'(mem_we), 64'd0);
    checkOutput("r_mem_wdata", 64'(mem_wdata), 64'd0);
    checkOutput("r_err", 64'(err), 64'd0);
    applyStimulus(0, '0, 0, 0, '0, '0, 1, 32'h77);
    step();
    checkOutput("r_no_rvalid", 64'({if_rvalid, d_rvalid}), 64'd0);
    rst = 1'b0;
    applyStimulus(1, 32'h0000_0044, 0, 0, '0, '0, 0, '0);
    step();
    checkOutput("r_new_if_gnt", 64'(if_gnt), 64'd1);
    checkOutput("r_new_mem_addr", 64'(mem_addr), 64'h44);
    applyStimulus(0, '0, 0, 0, '0, '0, 1, 32'hABC);
    step();
    checkOutput("r_new_if_rvalid", 64'(if_rvalid), 64'd1);
    checkOutput("r_new_rdata", 64'(rdata), 64'hABC);
    checkOutput("r_new_d_rvalid", 64'(d_rvalid), 64'd0);
    applyStimulus(0, '0, 0, 0, '0, '0, 0, '0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
